column_shift_driver: RTL and testbench
======================================

// Module: column_shift_driver
// PURPOSE
//  Downstream consumer of the rotational column buffer. On each angular-slot tick it reads the
//  two opposing columns (theta, theta+pi) from the buffer and shifts both out serially to the
//  two LED blade driver chains.
//  Sits between the buffer read port and the blade shift-register pins.
// PARAMETERS
//  ROTATIONAL_RES   1024  angular slots per revolution; theta width = $clog2(ROTATIONAL_RES)
//  DISPLAY_RADIUS   32    radial positions; radius width RW = $clog2(DISPLAY_RADIUS)
//  DISPLAY_HEIGHT   64    LEDs per column = bits shifted per blade per slot
//  READ_LATENCY     2     buffer read latency in clk_in cycles (HIGH_PERFORMANCE RAM)
//  CLK_DIV          2     ser_clk half-period in clk_in cycles (>=1)
// PORTS
//  clk_in        in   1          system clock
//  rst_in        in   1          asynchronous, active-high reset
//  theta_tick    in   1          1-cycle pulse: new angular slot begins
//  theta_in      in   TW         slot index valid with theta_tick
//  buf_busy      in   1          buffer busy (writing/flushing); read data invalid while high
//  columns_in    in   2x64       buffer read data, [0]=theta side, [1]=theta+pi side
//  radii_in      in   2xRW       buffer radius fields, same ordering
//  theta_read    out  TW         read address to buffer
//  ser_data      out  2          serial data, bit i = blade i
//  ser_clk       out  1          shared shift clock, data changes on falling edge
//  ser_latch     out  1          1-cycle-wide (in clk_in) latch strobe after last bit
//  ser_oe_n      out  1          blade output enable, active low
//  radii_out     out  2xRW       radius of currently displayed columns, updates with ser_latch
//  overrun       out  1          sticky: tick arrived with a pending tick already queued
// BEHAVIOUR
//  Reset: ser_data=0, ser_clk=0, ser_latch=0, ser_oe_n=1, theta_read=0, radii_out=0,
//   overrun=0, state=IDLE, pending=0. Reset is honoured mid-shift; pins return to reset values at once.
//  States: IDLE -> REQ -> WAIT_RD -> SHIFT -> LATCH -> IDLE.
//  IDLE: on theta_tick register theta_read<=theta_in, go REQ.
//  REQ/WAIT_RD: theta_read held stable. A counter reaches READ_LATENCY+1 consecutive cycles
//   with buf_busy=0, then captures columns_in/radii_in into shadow regs and goes to SHIFT.
//   Any buf_busy=1 cycle clears the counter; stall is unbounded.
//  SHIFT: DISPLAY_HEIGHT bits per blade, MSB first (z=63 first).
//   Each bit: ser_data set with ser_clk low for CLK_DIV cycles, then ser_clk high for CLK_DIV.
//   Total = DISPLAY_HEIGHT*2*CLK_DIV cycles; ser_clk low on exit.
//  LATCH: ser_latch=1 for one cycle; same cycle radii_out<=shadow radii, ser_oe_n<=0
//   (stays 0 until reset).
//  Tick while not IDLE: theta_in stored in a 1-deep pending slot (newest overwrites).
//   Overwriting an occupied slot sets overrun.
//   On leaving LATCH with pending set: go directly to REQ with the pending theta and clear pending.
//  Tick in the same cycle as leaving LATCH: treated as pending, serviced immediately (no loss).
//  Latency, tick to ser_latch, buf_busy=0: 1+(READ_LATENCY+1)+DISPLAY_HEIGHT*2*CLK_DIV+1 cycles.
//   Default = 261 cycles.
//  theta wrap (1023 -> 0) needs no special handling; the buffer maps the opposing half.
//  theta_read changes only on IDLE/LATCH exit, never during WAIT_RD or SHIFT.
// STRUCTURE
//  rot_display_pkg: driver_state_t enum and shared constants
//   (ROTATIONAL_RES, DISPLAY_RADIUS, DISPLAY_HEIGHT, derived TW/RW).
//  Sub-module shift_out_pair: two 64-bit shift regs + CLK_DIV divider + bit counter;
//   ports load/start/done.
// TESTING
//  1 tick theta=5, busy=0, col0=64'h8000_0000_0000_0001, col1=0 ->
//    theta_read=5; ser_data[0] bits 1,0..0,1; ser_latch at cycle 261.
//  2 busy held high 50 cycles after tick -> no capture and no ser_clk edge until busy
//    low for 3 cycles; latency grows by exactly 50.
//  3 second tick during SHIFT -> no overrun; serviced right after LATCH with the new theta_read.
//    Third tick in the same window -> overrun=1 and the latest theta is used.
//  4 tick theta=1023 then theta=0 -> theta_read 1023 then 0; radii_out follow radii_in at each latch.
//  5 rst_in asserted mid-SHIFT -> all outputs at reset values same cycle;
//    next tick after release runs a full clean cycle.
//  6 tick coincident with LATCH cycle -> serviced next, zero slots dropped across 100 back-to-back ticks.

Source files
------------

// File: rtl/rot_display_pkg.sv
// Shared geometry constants and the column driver state encoding for the rotational display.
package rot_display_pkg;
    localparam int ROTATIONAL_RES = 1024;
    localparam int DISPLAY_RADIUS = 32;
    localparam int DISPLAY_HEIGHT = 64;
    localparam int TW = $clog2(ROTATIONAL_RES);
    localparam int RW = $clog2(DISPLAY_RADIUS);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_RD,
        SHIFT,
        LATCH
    } driver_state_t;
endpackage

// File: rtl/shift_out_pair.sv
// Serialises two columns MSB-first onto a shared divided shift clock; data moves on the falling edge.
module shift_out_pair #(
    parameter int H  = 64,
    parameter int CD = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                load,
    input  logic                start,
    input  logic [1:0][H-1:0]   cols,
    output logic [1:0]          ser_data,
    output logic                ser_clk,
    output logic                done
);
    localparam int DW = (CD > 1) ? $clog2(CD) : 1;
    localparam int BW = $clog2(H);

    logic [1:0][H-1:0] sr;
    logic [DW-1:0]     div;
    logic [BW-1:0]     bits;
    logic              active;
    logic              phase;
    logic              last_div;

    assign last_div = (div == DW'(CD - 1));
    assign done     = active && phase && last_div && (bits == BW'(H - 1));
    assign ser_data = {sr[1][H-1], sr[0][H-1]};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            sr      <= '0;
            div     <= '0;
            bits    <= '0;
            active  <= 1'b0;
            phase   <= 1'b0;
            ser_clk <= 1'b0;
        end else begin
            if (load) sr <= cols;
            if (start) begin
                active  <= 1'b1;
                phase   <= 1'b0;
                div     <= '0;
                bits    <= '0;
                ser_clk <= 1'b0;
            end else if (active) begin
                if (last_div) begin
                    div <= '0;
                    if (!phase) begin
                        ser_clk <= 1'b1;
                        phase   <= 1'b1;
                    end else begin
                        // falling edge: advance to the next bit
                        ser_clk <= 1'b0;
                        phase   <= 1'b0;
                        sr[0]   <= {sr[0][H-2:0], 1'b0};
                        sr[1]   <= {sr[1][H-2:0], 1'b0};
                        bits    <= bits + BW'(1);
                        if (bits == BW'(H - 1)) active <= 1'b0;
                    end
                end else begin
                    div <= div + DW'(1);
                end
            end
        end
    end
endmodule

// File: rtl/column_shift_driver.sv
// Reads the opposing column pair for each angular slot and shifts it out to the two blade chains.
module column_shift_driver
    import rot_display_pkg::*;
#(
    parameter int READ_LATENCY = 2,
    parameter int CLK_DIV      = 2
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             theta_tick,
    input  logic [TW-1:0]                    theta_in,
    input  logic                             buf_busy,
    input  logic [1:0][DISPLAY_HEIGHT-1:0]   columns_in,
    input  logic [1:0][RW-1:0]               radii_in,
    output logic [TW-1:0]                    theta_read,
    output logic [1:0]                       ser_data,
    output logic                             ser_clk,
    output logic                             ser_latch,
    output logic                             ser_oe_n,
    output logic [1:0][RW-1:0]               radii_out,
    output logic                             overrun
);
    localparam int CW = $clog2(READ_LATENCY + 2);

    driver_state_t      state;
    logic [TW-1:0]      pend_theta;
    logic               pend_vld;
    logic [CW-1:0]      rd_cnt;
    logic [1:0][RW-1:0] radii_sh;
    logic               capture;
    logic               shift_done;

    // read data is trusted only after READ_LATENCY+1 consecutive non-busy cycles
    assign capture = ((state == REQ) || (state == WAIT_RD)) && !buf_busy &&
                     (rd_cnt == CW'(READ_LATENCY));

    shift_out_pair #(
        .H  (DISPLAY_HEIGHT),
        .CD (CLK_DIV)
    ) u_shift (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .load     (capture),
        .start    (capture),
        .cols     (columns_in),
        .ser_data (ser_data),
        .ser_clk  (ser_clk),
        .done     (shift_done)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            theta_read <= '0;
            pend_theta <= '0;
            pend_vld   <= 1'b0;
            rd_cnt     <= '0;
            radii_sh   <= '0;
            radii_out  <= '0;
            ser_latch  <= 1'b0;
            ser_oe_n   <= 1'b1;
            overrun    <= 1'b0;
        end else begin
            ser_latch <= 1'b0;
            if (theta_tick && state != IDLE) begin
                if (pend_vld) overrun <= 1'b1;
                pend_theta <= theta_in;
                pend_vld   <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (theta_tick) begin
                        theta_read <= theta_in;
                        rd_cnt     <= '0;
                        state      <= REQ;
                    end
                end
                REQ, WAIT_RD: begin
                    if (buf_busy) begin
                        rd_cnt <= '0;
                        state  <= WAIT_RD;
                    end else if (capture) begin
                        radii_sh <= radii_in;
                        state    <= SHIFT;
                    end else begin
                        rd_cnt <= rd_cnt + CW'(1);
                        state  <= WAIT_RD;
                    end
                end
                SHIFT: begin
                    if (shift_done) begin
                        ser_latch <= 1'b1;
                        radii_out <= radii_sh;
                        ser_oe_n  <= 1'b0;
                        state     <= LATCH;
                    end
                end
                LATCH: begin
                    // a tick landing on this cycle is taken directly instead of parking it
                    if (theta_tick || pend_vld) begin
                        theta_read <= theta_tick ? theta_in : pend_theta;
                        pend_vld   <= 1'b0;
                        rd_cnt     <= '0;
                        state      <= REQ;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_column_shift_driver.sv
// Scoreboard bench: ticks push expected column/radius/latency records, a monitor checks each latch.
module tb_column_shift_driver;
    import rot_display_pkg::*;

    logic                           clk_in = 1'b0;
    logic                           rst_in = 1'b1;
    logic                           theta_tick = 1'b0;
    logic [TW-1:0]                  theta_in = '0;
    logic                           buf_busy = 1'b0;
    logic [1:0][DISPLAY_HEIGHT-1:0] columns_in;
    logic [1:0][RW-1:0]             radii_in;
    logic [TW-1:0]                  theta_read;
    logic [1:0]                     ser_data;
    logic                           ser_clk;
    logic                           ser_latch;
    logic                           ser_oe_n;
    logic [1:0][RW-1:0]             radii_out;
    logic                           overrun;

    column_shift_driver #(.READ_LATENCY(2), .CLK_DIV(2)) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .theta_tick (theta_tick),
        .theta_in   (theta_in),
        .buf_busy   (buf_busy),
        .columns_in (columns_in),
        .radii_in   (radii_in),
        .theta_read (theta_read),
        .ser_data   (ser_data),
        .ser_clk    (ser_clk),
        .ser_latch  (ser_latch),
        .ser_oe_n   (ser_oe_n),
        .radii_out  (radii_out),
        .overrun    (overrun)
    );

    always #5 clk_in = ~clk_in;

    function automatic logic [63:0] col_of(input logic [TW-1:0] t, input int side);
        logic [15:0] c;
        c = {6'h2A, t};
        if (t == TW'(5)) return (side == 0) ? 64'h8000_0000_0000_0001 : 64'h0;
        return (side == 0) ? {c, ~c, c ^ 16'h5A5A, c + 16'd1} : {~c, c, 16'h1234, c};
    endfunction

    function automatic logic [RW-1:0] rad_of(input logic [TW-1:0] t, input int side);
        return (side == 0) ? t[RW-1:0] : ~t[RW-1:0];
    endfunction

    // buffer model: read data follows the requested address
    always_comb begin
        columns_in[0] = col_of(theta_read, 0);
        columns_in[1] = col_of(theta_read, 1);
        radii_in[0]   = rad_of(theta_read, 0);
        radii_in[1]   = rad_of(theta_read, 1);
    end

    typedef struct {
        logic [TW-1:0] th;
        logic [63:0]   c0;
        logic [63:0]   c1;
        logic [RW-1:0] r0;
        logic [RW-1:0] r1;
        int            lat;
        int            tcyc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   n_latched = 0;

    always @(posedge clk_in) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    logic [63:0] acc0 = '0, acc1 = '0;
    int          nbits = 0;
    logic        prev_clk = 1'b0;

    always @(negedge clk_in) begin
        exp_t e;
        if (rst_in) begin
            acc0 = '0; acc1 = '0; nbits = 0; prev_clk = 1'b0;
        end else begin
            if (ser_clk && !prev_clk) begin
                acc0 = {acc0[62:0], ser_data[0]};
                acc1 = {acc1[62:0], ser_data[1]};
                nbits++;
            end
            prev_clk = ser_clk;
            if (ser_latch) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL latch_unexpected: got latch with theta_read %0d, expected none", theta_read);
                end else begin
                    e = q.pop_front();
                    chk("theta_read_at_latch", 64'(theta_read), 64'(e.th));
                    chk("col0_bits", acc0, e.c0);
                    chk("col1_bits", acc1, e.c1);
                    chk("bit_count", 64'(nbits), 64'd64);
                    chk("radii_out0", 64'(radii_out[0]), 64'(e.r0));
                    chk("radii_out1", 64'(radii_out[1]), 64'(e.r1));
                    if (e.lat >= 0) chk("latency", 64'(cyc - e.tcyc), 64'(e.lat));
                end
                n_latched++;
                acc0 = '0; acc1 = '0; nbits = 0;
            end
        end
    end

    // called at a negedge; returns at the following negedge
    task automatic tick(input logic [TW-1:0] t, input int lat);
        exp_t e;
        e.th = t; e.c0 = col_of(t, 0); e.c1 = col_of(t, 1);
        e.r0 = rad_of(t, 0); e.r1 = rad_of(t, 1);
        e.lat = lat; e.tcyc = cyc;
        q.push_back(e);
        theta_in = t;
        theta_tick = 1'b1;
        @(negedge clk_in);
        theta_tick = 1'b0;
    endtask

    task automatic wait_drain(input int max_cyc);
        int n;
        n = 0;
        while (q.size() != 0 && n < max_cyc) begin
            @(negedge clk_in);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", q.size());
            q.delete();
        end
        repeat (2) @(negedge clk_in);
    endtask

    task automatic chk_reset_pins(input string tag);
        chk({tag, "_ser_data"},   64'(ser_data),   64'd0);
        chk({tag, "_ser_clk"},    64'(ser_clk),    64'd0);
        chk({tag, "_ser_latch"},  64'(ser_latch),  64'd0);
        chk({tag, "_ser_oe_n"},   64'(ser_oe_n),   64'd1);
        chk({tag, "_theta_read"}, 64'(theta_read), 64'd0);
        chk({tag, "_radii_out"},  64'(radii_out),  64'd0);
        chk({tag, "_overrun"},    64'(overrun),    64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1);
    end

    initial begin
        int n, base;
        repeat (3) @(negedge clk_in);
        chk_reset_pins("reset");
        rst_in = 1'b0;
        @(negedge clk_in);

        // 1: single slot, latch 260 cycles after the tick cycle
        tick(5, 260);
        chk("t1_theta_read", 64'(theta_read), 64'd5);
        wait_drain(400);
        chk("t1_oe_n_low", 64'(ser_oe_n), 64'd0);
        chk("t1_clk_low", 64'(ser_clk), 64'd0);

        // 2: buffer busy for 50 cycles stretches latency by exactly 50
        buf_busy = 1'b1;
        tick(100, 310);
        repeat (50) @(negedge clk_in);
        chk("t2_no_bits_while_busy", 64'(nbits), 64'd0);
        chk("t2_theta_read", 64'(theta_read), 64'd100);
        buf_busy = 1'b0;
        wait_drain(500);

        // 3: pending slot, then overwrite -> overrun, newest theta serviced right after latch
        tick(20, 260);
        repeat (100) @(negedge clk_in);
        tick(21, -1);
        chk("t3_no_overrun", 64'(overrun), 64'd0);
        repeat (10) @(negedge clk_in);
        void'(q.pop_back());
        tick(22, 408);
        chk("t3_overrun", 64'(overrun), 64'd1);
        chk("t3_theta_held", 64'(theta_read), 64'd20);
        wait_drain(800);

        // 4: wrap of the angular index
        tick(1023, 260);
        chk("t4_theta_1023", 64'(theta_read), 64'd1023);
        wait_drain(400);
        tick(0, 260);
        chk("t4_theta_0", 64'(theta_read), 64'd0);
        wait_drain(400);

        // 5: reset mid-shift clears pins immediately, then a clean slot
        tick(7, -1);
        repeat (100) @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk_reset_pins("midshift");
        q.delete();
        repeat (2) @(negedge clk_in);
        rst_in = 1'b0;
        @(negedge clk_in);
        tick(9, 260);
        wait_drain(400);

        // 6: each tick lands on the latch cycle; nothing may be dropped
        base = n_latched;
        tick(300, 260);
        for (int i = 0; i < 100; i++) begin
            n = 0;
            while (!ser_latch && n < 400) begin
                @(negedge clk_in);
                n++;
            end
            if (!ser_latch) begin
                total++;
                $display("FAIL t6_latch_timeout: got no latch at slot %0d, expected latch", i);
                break;
            end
            tick(TW'(301 + i), 260);
        end
        wait_drain(400);
        chk("t6_latch_count", 64'(n_latched - base), 64'd101);
        chk("t6_no_overrun", 64'(overrun), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
